// File: rtl/fetch_decode_stage_if.sv
// Bundle between the fetch/decode stage and its neighbours: hazard/redirect control,
// instruction-memory fetch port, and the decoded IF/ID fields toward ControlUnit.
// master = the fetch stage itself, slave = the surrounding pipeline and memory.
interface fetch_decode_stage_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [1:0]        op;
    logic [1:0]        inst;
    logic              immediate;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [14:0]       imm_field;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_en, imem_addr, id_valid, id_pc,
               op, inst, immediate, rd, rs1, rs2, imm_field
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_en, imem_addr, id_valid, id_pc,
               op, inst, immediate, rd, rs1, rs2, imm_field
    );
endinterface

// File: rtl/fetch_decode_stage.sv
// Instruction fetch (PC + sync-read imem request) and IF/ID register with field slicing.
// Latency: word at pc=A lands in IF/ID 2 edges later; redirect costs exactly 2 bubbles.
// Backpressure: stall freezes pc, in-flight request and IF/ID; redirect overrides stall.
module fetch_decode_stage #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_decode_stage_if.master   bus
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc_q;
    logic              req_valid_q;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc_q;
    logic              id_valid_q;
    logic [ADDR_W-1:0] target_pc;
    logic              advance;

    // Targets are forced word-aligned so pc can never leave a word boundary.
    assign target_pc = bus.redirect_pc & ~ADDR_W'(3);
    assign advance   = ~bus.stall & ~bus.redirect;

    // Memory only needs to read when the fetch actually moves or restarts;
    // while stalled it keeps rdata, which is the word IF/ID will still need.
    assign bus.imem_en   = ~bus.stall | bus.redirect;
    assign bus.imem_addr = pc;

    // Program counter: restart on redirect, step by one word otherwise (wraps).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (bus.redirect) begin
            pc <= target_pc;
        end else if (advance) begin
            pc <= pc + ADDR_W'(4);
        end
    end

    // Fetch-in-flight tracker: remembers which address the memory is returning next
    // and whether that word is on the correct path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else if (bus.redirect) begin
            req_valid_q <= 1'b0;
        end else if (advance) begin
            req_pc_q    <= pc;
            req_valid_q <= 1'b1;
        end
    end

    // IF/ID register: captures the returned word, or a NOP bubble when the
    // in-flight word was never requested or belongs to a flushed path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instr   <= NOP_INSTR;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
        end else if (bus.redirect) begin
            id_instr   <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else if (advance) begin
            id_instr   <= req_valid_q ? bus.imem_rdata : NOP_INSTR;
            id_pc_q    <= req_pc_q;
            id_valid_q <= req_valid_q;
        end
    end

    assign bus.id_valid  = id_valid_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.op        = id_instr[31:30];
    assign bus.inst      = id_instr[29:28];
    assign bus.immediate = id_instr[27];
    assign bus.rd        = id_instr[26:23];
    assign bus.rs1       = id_instr[22:19];
    assign bus.rs2       = id_instr[18:15];
    assign bus.imm_field = id_instr[14:0];
endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed + random bench for fetch_decode_stage with a transaction-level reference model.
// Memory content is a pure function of the address, so the expected IF/ID word is
// derived from the expected PC rather than from anything the DUT returned.
module tb_fetch_decode_stage;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    fetch_decode_stage_if #(.ADDR_W(32)) bus ();
    fetch_decode_stage_if #(.ADDR_W(32)) bus2 ();

    fetch_decode_stage #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    fetch_decode_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0)) u_wrap (
        .clk(clk), .rst(rst2), .bus(bus2.master)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] salt = 32'h0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ((a >> 2) * 32'h1111_1111) ^ salt;
    endfunction

    // Behavioural synchronous-read instruction memory.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= word_at(bus.imem_addr);
    end

    // Reference model: next fetch PC, the address whose word is on its way
    // (if on the correct path), and the instruction visible in IF/ID.
    logic [31:0] m_pc, m_fpc, m_ipc, m_iword;
    logic        m_fv, m_iv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_fpc = 32'h0; m_fv = 1'b0;
        m_iv = 1'b0; m_ipc = 32'h0; m_iword = 32'h0;
    endtask

    task automatic model_edge();
        if (bus.redirect) begin
            m_pc    = bus.redirect_pc & 32'hFFFF_FFFC;
            m_fv    = 1'b0;
            m_iv    = 1'b0;
            m_iword = 32'h0;
        end else if (!bus.stall) begin
            m_iv    = m_fv;
            m_ipc   = m_fpc;
            m_iword = m_fv ? word_at(m_fpc) : 32'h0;
            m_fv    = 1'b1;
            m_fpc   = m_pc;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    function automatic logic [31:0] fields();
        return {bus.op, bus.inst, bus.immediate, bus.rd, bus.rs1, bus.rs2, bus.imm_field};
    endfunction

    task automatic check_state();
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("id_valid", {31'h0, bus.id_valid}, {31'h0, m_iv});
        chk("fields", fields(), m_iword);
        if (m_iv) chk("id_pc", bus.id_pc, m_ipc);
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] t);
        bus.stall = s; bus.redirect = r; bus.redirect_pc = t;
    endtask

    task automatic cyc();
        #1;
        chk("imem_en", {31'h0, bus.imem_en}, {31'h0, (~bus.stall | bus.redirect)});
        @(posedge clk);
        model_edge();
        #1;
        check_state();
    endtask

    // Asserts reset off-edge, verifies the immediate clear, releases off-edge.
    task automatic do_reset(input logic [31:0] new_salt);
        #2;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        salt = new_salt;
        model_reset();
        #1;
        check_state();
        chk("rst_id_pc", bus.id_pc, 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] frozen_addr;
        int          guard;
        rst  = 1'b1;
        rst2 = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        bus2.stall = 1'b0; bus2.redirect = 1'b0; bus2.redirect_pc = 32'h0;
        bus2.imem_rdata = 32'h0;
        model_reset();

        // Reset state of both instances, then pc wrap on the high-reset-PC copy.
        #12;
        check_state();
        chk("rst_id_pc", bus.id_pc, 32'h0);
        chk("wrap_reset_pc", bus2.imem_addr, 32'hFFFF_FFFC);
        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("wrap_to_zero", bus2.imem_addr, 32'h0);
        @(posedge clk); #1;
        chk("wrap_then_4", bus2.imem_addr, 32'h4);
        #2;
        rst = 1'b0;

        // Sequential run: first valid word on the 2nd edge after reset release.
        cyc();
        chk("t1_edge1_bubble", {31'h0, bus.id_valid}, 32'h0);
        cyc();
        chk("t1_edge2_valid", {31'h0, bus.id_valid}, 32'h1);
        chk("t1_edge2_pc", bus.id_pc, 32'h0);
        cyc();
        chk("t1_edge3_pc", bus.id_pc, 32'h4);
        chk("t1_edge3_word", fields(), 32'h1111_1111);

        // Stall three cycles while IF/ID holds pc 8.
        guard = 0;
        while (!(bus.id_valid && bus.id_pc == 32'h8) && guard < 20) begin
            cyc();
            guard++;
        end
        chk("t3_reached_pc8", bus.id_pc, 32'h8);
        frozen_addr = bus.imem_addr;
        drive(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_hold_id_pc", bus.id_pc, 32'h8);
            chk("t3_hold_addr", bus.imem_addr, frozen_addr);
            chk("t3_hold_word", fields(), 32'h2222_2222);
        end
        drive(1'b0, 1'b0, 32'h0);
        cyc();
        chk("t3_resume_pc12", bus.id_pc, 32'hC);
        chk("t3_resume_word", fields(), 32'h3333_3333);

        // Field slicing: B9A3_C123 -> 10|11|1|0011|0100|0111|100_0001_0010_0011.
        do_reset(32'hB9A3_C123);
        cyc();
        cyc();
        chk("t2_op", {30'h0, bus.op}, 32'h2);
        chk("t2_inst", {30'h0, bus.inst}, 32'h3);
        chk("t2_immediate", {31'h0, bus.immediate}, 32'h1);
        chk("t2_rd", {28'h0, bus.rd}, 32'h3);
        chk("t2_rs1", {28'h0, bus.rs1}, 32'h4);
        chk("t2_rs2", {28'h0, bus.rs2}, 32'h7);
        chk("t2_imm_field", {17'h0, bus.imm_field}, 32'h4123);

        // Redirect to 0x40 while IF/ID holds pc 4: two bubbles, then 0x40, 0x44.
        cyc();
        chk("t4_at_pc4", bus.id_pc, 32'h4);
        drive(1'b0, 1'b1, 32'h40);
        cyc();
        chk("t4_bubble1", {31'h0, bus.id_valid}, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        cyc();
        chk("t4_bubble2", {31'h0, bus.id_valid}, 32'h0);
        cyc();
        chk("t4_first_pc", bus.id_pc, 32'h40);
        chk("t4_first_valid", {31'h0, bus.id_valid}, 32'h1);
        cyc();
        chk("t4_second_pc", bus.id_pc, 32'h44);

        // Redirect beats stall; misaligned target bits dropped; last redirect wins.
        drive(1'b1, 1'b1, 32'h83);
        cyc();
        chk("t5_pc_target", bus.imem_addr, 32'h80);
        drive(1'b0, 1'b1, 32'h100);
        cyc();
        drive(1'b0, 1'b1, 32'h200);
        cyc();
        drive(1'b0, 1'b0, 32'h0);
        guard = 0;
        while (!bus.id_valid && guard < 10) begin
            cyc();
            guard++;
        end
        chk("t5_first_valid_pc", bus.id_pc, 32'h200);
        chk("t5_reached_valid", {31'h0, bus.id_valid}, 32'h1);

        // Mid-run reset (off-edge) must clear immediately and restart from 0.
        cyc();
        do_reset(32'h0);
        cyc();
        cyc();
        chk("t6_restart_pc", bus.id_pc, 32'h0);

        // Random stall/redirect traffic against the model.
        do_reset($urandom);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom & 32'h0000_0FFF);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
